dbg_host: RTL and testbench
===========================

# dbg_host

Host-side initiator for the single-byte UART debug protocol (`i` status, `a` address + 2 bytes big-endian, `w` write byte with addr++, `r` read byte with addr++). Accepts one memory-access request at a time, serializes it into command bytes on a byte-wide TX handshake, and collects the one-byte reply from the RX byte strobe. Sits between a debug controller/test sequencer and a UART transmitter/receiver pair whose far end is the on-target debug UART slave. Keeps a shadow of the target's auto-incrementing address to skip redundant `a` sequences.

## Interface
- `TIMEOUT`, 16'hFFFF: cycles to wait in WAIT_RSP for a reply byte before flagging an error (1..65535).
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; transfer on `req_valid & req_ready`.
- `req_op` in 2: 00 status, 01 read, 10 write, 11 reserved (completes as error, no bytes sent).
- `req_addr` in 16: byte address (read/write).
- `req_wdata` in 8: write byte.
- `tx_valid` out 1: byte offered to UART TX.
- `tx_data` out 8: byte value, stable while `tx_valid` high.
- `tx_ready` in 1: TX accepts; byte transfers on `tx_valid & tx_ready`.
- `rx_valid` in 1: one-cycle strobe, received byte present.
- `rx_data` in 8: received byte.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: reply byte (status/read), 0 for write/error.
- `rsp_err` out 1: qualifies `rsp_valid`; timeout or reserved op.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, CMD_A, ADDR_H, ADDR_L, OP, WDATA, WAIT_RSP.
- IDLE: on handshake latch op/addr/wdata. Status → OP. Read/write → CMD_A if address needed, else OP. Reserved → IDLE with `rsp_valid`=1, `rsp_err`=1 next cycle.
- Address needed for read/write when shadow invalid or `req_addr` ≠ shadow.
- CMD_A sends 0x61, ADDR_H sends `addr[15:8]`, ADDR_L sends `addr[7:0]`; each state advances only on TX handshake.
- OP sends 0x69 (status), 0x72 (read), 0x77 (write). Write → WDATA; status/read → WAIT_RSP.
- WDATA sends `wdata`, then IDLE with `rsp_valid`=1, `rsp_err`=0, `rsp_data`=0.
- WAIT_RSP: first `rx_valid` → `rsp_data`=`rx_data`, `rsp_err`=0, IDLE. `rx_valid` in any other state is ignored.
- Timeout: counter cleared on WAIT_RSP entry, increments each WAIT_RSP cycle without `rx_valid`; at TIMEOUT cycles → `rsp_err`=1, `rsp_data`=0, shadow invalidated, IDLE. `rx_valid` on the expiry cycle wins (normal reply).
- Shadow: on successful read/write completion, shadow = addr+1 mod 2^16 (0xFFFF → 0x0000), marked valid. Status leaves shadow unchanged.

## Timing
- Reset values: `tx_valid` 0, `tx_data` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `busy` 0, `req_ready` 0 during reset, 1 from first edge after release; shadow invalid.
- Request accepted at edge 0 → `tx_valid` high from cycle 1; one byte per cycle while `tx_ready`=1.
- `tx_data` must not change while `tx_valid`=1 and `tx_ready`=0.
- `rsp_valid` asserts the cycle after the completing event (last TX handshake, `rx_valid`, or expiry); `req_ready` rises the same cycle; new request may be accepted then.
- Reset mid-transfer: `tx_valid` drops immediately (asynchronous), partial command abandoned, no `rsp_valid`.

## Configuration
- `DBG_HOST_ADDR_CACHE_EN` defined: shadow-address skip as above.
- Undefined: shadow logic removed; every read/write sends `a`+2 address bytes; status unaffected.

## Test plan
- Status, `tx_ready`=1, `rx_valid`+0x5A two cycles after 0x69 → TX 0x69 only, `rsp_valid` with `rsp_data`=0x5A, `rsp_err`=0.
- Write 0x1234/0xAB from reset → TX 0x61,0x12,0x34,0x77,0xAB on cycles 1–5, `rsp_valid` cycle 6; then read 0x1235 → TX 0x72 only (macro on), 0x61,0x12,0x35,0x72 (macro off).
- Write 0xFFFF then write 0x0000 → second write sends 0x77,data only (wrap-around, macro on).
- `tx_ready` toggled 1-of-3 cycles during a read → bytes unchanged in order, `tx_data` stable while stalled.
- Read with no reply, TIMEOUT=16 → `rsp_err`=1, `rsp_data`=0 after 16 WAIT_RSP cycles; next read to same address re-sends `a`.
- `reset` asserted after ADDR_H handshake → `tx_valid` 0 immediately, no `rsp_valid`, next request restarts with 0x61.

Source files
------------

// File: rtl/dbg_host.sv
// ============================================================================
// Module      : dbg_host
// Description : Host-side initiator for the single-byte UART debug protocol.
//               Serializes status/read/write requests into command bytes and
//               collects the one-byte reply. Optional feature macro:
//               DBG_HOST_ADDR_CACHE_EN (shadow-address skip of 'a' sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_host #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] c_OP_STATUS = 2'b00;
  localparam logic [1:0] c_OP_READ   = 2'b01;
  localparam logic [1:0] c_OP_WRITE  = 2'b10;
  localparam logic [1:0] c_OP_RSVD   = 2'b11;

  localparam logic [7:0] c_CMD_ADDR   = 8'h61;
  localparam logic [7:0] c_CMD_STATUS = 8'h69;
  localparam logic [7:0] c_CMD_READ   = 8'h72;
  localparam logic [7:0] c_CMD_WRITE  = 8'h77;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD_A    = 3'd1,
    S_ADDR_H   = 3'd2,
    S_ADDR_L   = 3'd3,
    S_OP       = 3'd4,
    S_WDATA    = 3'd5,
    S_WAIT_RSP = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_started;
  logic [1:0]  r_op;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [15:0] r_cnt;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_need_addr;
  logic        w_done;
  logic        w_done_err;
  logic [7:0]  w_done_data;

  assign req_ready = r_started && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // tx_data is decoded from state and latched request fields only, so it
  // cannot move while a byte is stalled on tx_ready.
  always_comb begin
    w_next      = r_state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_done_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (req_op)
            c_OP_STATUS: w_next = S_OP;
            c_OP_READ,
            c_OP_WRITE:  w_next = w_need_addr ? S_CMD_A : S_OP;
            default: begin
              w_done     = 1'b1;
              w_done_err = 1'b1;
            end
          endcase
        end
      end
      S_CMD_A: begin
        tx_valid = 1'b1;
        tx_data  = c_CMD_ADDR;
        if (tx_ready) w_next = S_ADDR_H;
      end
      S_ADDR_H: begin
        tx_valid = 1'b1;
        tx_data  = r_addr[15:8];
        if (tx_ready) w_next = S_ADDR_L;
      end
      S_ADDR_L: begin
        tx_valid = 1'b1;
        tx_data  = r_addr[7:0];
        if (tx_ready) w_next = S_OP;
      end
      S_OP: begin
        tx_valid = 1'b1;
        case (r_op)
          c_OP_STATUS: tx_data = c_CMD_STATUS;
          c_OP_READ:   tx_data = c_CMD_READ;
          default:     tx_data = c_CMD_WRITE;
        endcase
        if (tx_ready) w_next = (r_op == c_OP_WRITE) ? S_WDATA : S_WAIT_RSP;
      end
      S_WDATA: begin
        tx_valid = 1'b1;
        tx_data  = r_wdata;
        if (tx_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WAIT_RSP: begin
        // A reply arriving on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          w_done      = 1'b1;
          w_done_data = rx_data;
          w_next      = S_IDLE;
        end else if (r_cnt == TIMEOUT - 16'd1) begin
          w_done     = 1'b1;
          w_done_err = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_started   <= 1'b0;
      r_op        <= c_OP_STATUS;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_cnt       <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
    end else begin
      r_started   <= 1'b1;
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_data <= w_done_data;
        r_rsp_err  <= w_done_err;
      end
      if (w_accept) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      r_cnt <= (r_state == S_WAIT_RSP) ? r_cnt + 16'd1 : 16'h0000;
    end
  end

`ifdef DBG_HOST_ADDR_CACHE_EN
  logic [15:0] r_shadow;
  logic        r_shadow_vld;

  assign w_need_addr = !r_shadow_vld || (req_addr != r_shadow);

  // Error completions carry no reply, so only read/write successes update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow     <= 16'h0000;
      r_shadow_vld <= 1'b0;
    end else if (w_done && !w_done_err &&
                 ((r_op == c_OP_READ) || (r_op == c_OP_WRITE))) begin
      r_shadow     <= r_addr + 16'd1;
      r_shadow_vld <= 1'b1;
    end else if (w_done && w_done_err && (r_state == S_WAIT_RSP)) begin
      r_shadow_vld <= 1'b0;
    end
  end
`else
  assign w_need_addr = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dbg_host.sv
// ============================================================================
// Module      : tb_dbg_host
// Description : Scoreboard bench for dbg_host; expected TX bytes and responses
//               are queued by the stimulus and checked by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbg_host;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] q_tx[$];
  logic [8:0] q_rsp[$];

  logic       r_prev_stall = 1'b0;
  logic [7:0] r_prev_data  = 8'h00;

  dbg_host #(.TIMEOUT(16'd16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: handshakes visible at the negedge complete on the next posedge.
  always @(negedge clk) begin
    if (tx_valid && r_prev_stall)
      chk("tx_data_stable", {24'h0, tx_data}, {24'h0, r_prev_data});
    if (tx_valid && tx_ready) begin
      if (q_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'h0, tx_data}, {24'h0, q_tx.pop_front()});
    end
    r_prev_stall = tx_valid && !tx_ready;
    r_prev_data  = tx_data;
    if (rsp_valid) begin
      if (q_rsp.size() == 0) chk("rsp_unexpected", {23'h0, rsp_err, rsp_data}, 32'hFFFF_FFFF);
      else chk("rsp_err_data", {23'h0, rsp_err, rsp_data}, {23'h0, q_rsp.pop_front()});
    end
  end

  task automatic exp_tx(input logic [7:0] b);
    q_tx.push_back(b);
  endtask

  task automatic exp_rsp(input logic err, input logic [7:0] d);
    q_rsp.push_back({err, d});
  endtask

  // Issues one request (caller is at posedge+1) and waits for its response.
  task automatic run(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                     input bit give_rx, input logic [7:0] rxd, input int rx_dly,
                     input int exp_lat, input bit stall);
    int nb;
    int cyc;
    int hs;
    int wt;
    bit done;
    nb = q_tx.size();
    cyc = 0; hs = 0; wt = 0; done = 0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!done && cyc < 200) begin
      rx_valid = 1'b0;
      if (stall) tx_ready = (cyc % 3 == 2);
      if (give_rx && hs == nb) begin
        if (wt == rx_dly) begin
          rx_valid = 1'b1;
          rx_data  = rxd;
        end
        wt++;
      end
      @(negedge clk);
      cyc++;
      if (rsp_valid) done = 1;
      else if (tx_valid && tx_ready) hs++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    if (!done) chk("rsp_timeout", 32'(cyc), 32'd0);
    else if (exp_lat >= 0) chk("rsp_latency", 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0;
    req_wdata = 8'h0; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("rst_rsp", {22'h0, rsp_valid, rsp_err, rsp_data}, 32'd0);
    chk("rst_busy_ready", {30'h0, busy, req_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", {31'h0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", {31'h0, req_ready}, 32'd1);

    // Status with reply two cycles into WAIT_RSP
    exp_tx(8'h69); exp_rsp(1'b0, 8'h5A);
    run(2'b00, 16'h0, 8'h0, 1, 8'h5A, 2, 5, 0);

    // Write from invalid shadow: full address sequence, rsp on cycle 6
    exp_tx(8'h61); exp_tx(8'h12); exp_tx(8'h34); exp_tx(8'h77); exp_tx(8'hAB);
    exp_rsp(1'b0, 8'h00);
    run(2'b10, 16'h1234, 8'hAB, 0, 8'h0, 0, 6, 0);

`ifdef DBG_HOST_ADDR_CACHE_EN
    exp_tx(8'h72);
    exp_rsp(1'b0, 8'hC3);
    run(2'b01, 16'h1235, 8'h0, 1, 8'hC3, 0, 3, 0);
`else
    exp_tx(8'h61); exp_tx(8'h12); exp_tx(8'h35); exp_tx(8'h72);
    exp_rsp(1'b0, 8'hC3);
    run(2'b01, 16'h1235, 8'h0, 1, 8'hC3, 0, 6, 0);
`endif

    // Address wrap-around 0xFFFF -> 0x0000
    exp_tx(8'h61); exp_tx(8'hFF); exp_tx(8'hFF); exp_tx(8'h77); exp_tx(8'h5E);
    exp_rsp(1'b0, 8'h00);
    run(2'b10, 16'hFFFF, 8'h5E, 0, 8'h0, 0, 6, 0);
`ifdef DBG_HOST_ADDR_CACHE_EN
    exp_tx(8'h77); exp_tx(8'hA5);
    exp_rsp(1'b0, 8'h00);
    run(2'b10, 16'h0000, 8'hA5, 0, 8'h0, 0, 3, 0);
`else
    exp_tx(8'h61); exp_tx(8'h00); exp_tx(8'h00); exp_tx(8'h77); exp_tx(8'hA5);
    exp_rsp(1'b0, 8'h00);
    run(2'b10, 16'h0000, 8'hA5, 0, 8'h0, 0, 6, 0);
`endif

    // Read with tx_ready high one cycle in three
    exp_tx(8'h61); exp_tx(8'h43); exp_tx(8'h21); exp_tx(8'h72);
    exp_rsp(1'b0, 8'h96);
    run(2'b01, 16'h4321, 8'h0, 1, 8'h96, 1, -1, 1);

    // Timeout after 16 WAIT_RSP cycles, then address is re-sent
    exp_tx(8'h61); exp_tx(8'h70); exp_tx(8'h00); exp_tx(8'h72);
    exp_rsp(1'b1, 8'h00);
    run(2'b01, 16'h7000, 8'h0, 0, 8'h0, 0, 21, 0);
    exp_tx(8'h61); exp_tx(8'h70); exp_tx(8'h00); exp_tx(8'h72);
    exp_rsp(1'b0, 8'h11);
    run(2'b01, 16'h7000, 8'h0, 1, 8'h11, 1, 7, 0);

    // Reserved op: error next cycle, no bytes, shadow untouched
    exp_rsp(1'b1, 8'h00);
    run(2'b11, 16'h7001, 8'h0, 0, 8'h0, 0, 1, 0);
    // Status in between must not disturb the shadow either
    exp_tx(8'h69); exp_rsp(1'b0, 8'h3C);
    run(2'b00, 16'h0, 8'h0, 1, 8'h3C, 0, 3, 0);
`ifdef DBG_HOST_ADDR_CACHE_EN
    exp_tx(8'h72);
    exp_rsp(1'b0, 8'h44);
    run(2'b01, 16'h7001, 8'h0, 1, 8'h44, 0, 3, 0);
`else
    exp_tx(8'h61); exp_tx(8'h70); exp_tx(8'h01); exp_tx(8'h72);
    exp_rsp(1'b0, 8'h44);
    run(2'b01, 16'h7001, 8'h0, 1, 8'h44, 0, 6, 0);
`endif

    // Reset right after the ADDR_H handshake
    exp_tx(8'h61); exp_tx(8'h55);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h5555; req_wdata = 8'h66;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_tx_valid", {31'h0, tx_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_tx_valid", {31'h0, tx_valid}, 32'd0);
    chk("async_reset_busy", {31'h0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    exp_tx(8'h61); exp_tx(8'h55); exp_tx(8'h55); exp_tx(8'h77); exp_tx(8'h66);
    exp_rsp(1'b0, 8'h00);
    run(2'b10, 16'h5555, 8'h66, 0, 8'h0, 0, 6, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("tx_queue_drained", 32'(q_tx.size()), 32'd0);
    chk("rsp_queue_drained", 32'(q_rsp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
